// File: rtl/dw_pkg.sv
// Shared sizing, tap constants and lane-slice helpers for the depthwise 3x3 MAC array.
package dw_pkg;

  localparam int unsigned UNIT_NUM  = 16;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned LANE_W    = DATA_W;
  localparam int unsigned K         = 3;
  localparam int unsigned KK        = K * K;
  localparam int unsigned TAP_IDX_W = 4;
  localparam int unsigned ACC_W     = 20;
  localparam int unsigned PROD_W    = 2 * DATA_W;
  localparam int unsigned VEC_W     = UNIT_NUM * LANE_W;
  localparam int unsigned OUT_W     = UNIT_NUM * ACC_W;

  localparam logic [KK-1:0]        FULL_MASK = 9'h1FF;
  localparam logic [TAP_IDX_W-1:0] LAST_TAP  = TAP_IDX_W'(KK - 1);

  // Low bit of lane i inside a packed weight/activation vector.
  function automatic int unsigned lane_lo(input int unsigned lane);
    return lane * LANE_W;
  endfunction

  // Low bit of lane i inside the packed accumulator vector.
  function automatic int unsigned acc_lo(input int unsigned lane);
    return lane * ACC_W;
  endfunction

endpackage

// File: rtl/dw_mac_array_lane.sv
// One channel lane: registered signed product, then accumulate across the taps of a window.
module dw_lane_mac
  import dw_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LANE_W-1:0] act,
  input  logic [LANE_W-1:0] wgt,
  input  logic              acc_en,
  input  logic              first,
  input  logic              clear,
  output logic [ACC_W-1:0]  sum_c
);

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum_s;

  always_comb begin
    prod_d = prod_q;
    if (load) begin
      prod_d = PROD_W'($signed(act)) * PROD_W'($signed(wgt));
    end
    prod_ext = ACC_W'(prod_q);
    // The first tap of a window restarts the sum instead of adding to stale state.
    sum_s = first ? prod_ext : (acc_q + prod_ext);
    sum_c = sum_s;
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = sum_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/dw_mac_array.sv
// Depthwise 3x3 MAC array: holds one weight set, streams 9-tap windows, emits a 16-lane sum.
module dw_mac_array
  import dw_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 w_valid,
  input  logic [TAP_IDX_W-1:0] w_idx,
  input  logic [VEC_W-1:0]     w_data,
  output logic                 weights_ready,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [VEC_W-1:0]     act_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 window_abort
);

  logic [VEC_W-1:0]     wbuf_q [KK];
  logic [VEC_W-1:0]     wbuf_d [KK];
  logic [KK-1:0]        mask_q, mask_d;
  logic                 weights_ready_q, weights_ready_d;
  logic [TAP_IDX_W-1:0] tap_cnt_q, tap_cnt_d;
  logic                 p_valid_q, p_valid_d;
  logic                 p_first_q, p_first_d;
  logic                 p_last_q, p_last_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic                 window_abort_q, window_abort_d;

  logic                 w_ok, new_set, act_ready_c, act_fire, acc_en, last_done;
  logic [VEC_W-1:0]     wsel;
  logic [OUT_W-1:0]     sum_vec;

  always_comb begin
    w_ok        = w_valid && (w_idx <= LAST_TAP);
    new_set     = w_valid && (w_idx == '0);
    // Only the closing tap is held back while a finished result is still stalled.
    act_ready_c = weights_ready_q && !((tap_cnt_q == LAST_TAP) && out_valid_q && !out_ready);
    act_fire    = act_valid && act_ready_c;
    acc_en      = p_valid_q && !new_set;
    last_done   = acc_en && p_last_q;
    wsel        = wbuf_q[tap_cnt_q];

    wbuf_d = wbuf_q;
    mask_d = mask_q;
    if (w_ok) begin
      wbuf_d[w_idx] = w_data;
      mask_d        = new_set ? KK'(1) : (mask_q | (KK'(1) << w_idx));
    end
    weights_ready_d = (mask_d == FULL_MASK);

    // A new weight set mid-window discards the partial window, including a same-cycle beat.
    window_abort_d = new_set && ((tap_cnt_q != '0) || p_valid_q || act_fire);
    tap_cnt_d      = tap_cnt_q;
    p_valid_d      = 1'b0;
    p_first_d      = p_first_q;
    p_last_d       = p_last_q;
    if (new_set) begin
      tap_cnt_d = '0;
    end else if (act_fire) begin
      p_valid_d = 1'b1;
      p_first_d = (tap_cnt_q == '0);
      p_last_d  = (tap_cnt_q == LAST_TAP);
      tap_cnt_d = (tap_cnt_q == LAST_TAP) ? '0 : (tap_cnt_q + TAP_IDX_W'(1));
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (last_done) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_vec;
    end
  end

  for (genvar i = 0; i < UNIT_NUM; i++) begin : g_lane
    dw_lane_mac u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (act_fire),
      .act    (act_data[lane_lo(i) +: LANE_W]),
      .wgt    (wsel[lane_lo(i) +: LANE_W]),
      .acc_en (acc_en),
      .first  (p_first_q),
      .clear  (new_set),
      .sum_c  (sum_vec[acc_lo(i) +: ACC_W])
    );
  end

  // Weight storage carries no reset; the tap mask decides when it is meaningful.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q          <= '0;
      weights_ready_q <= 1'b0;
      tap_cnt_q       <= '0;
      p_valid_q       <= 1'b0;
      p_first_q       <= 1'b0;
      p_last_q        <= 1'b0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      window_abort_q  <= 1'b0;
    end else begin
      mask_q          <= mask_d;
      weights_ready_q <= weights_ready_d;
      tap_cnt_q       <= tap_cnt_d;
      p_valid_q       <= p_valid_d;
      p_first_q       <= p_first_d;
      p_last_q        <= p_last_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      window_abort_q  <= window_abort_d;
    end
  end

  assign weights_ready = weights_ready_q;
  assign act_ready     = act_ready_c;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign window_abort  = window_abort_q;

endmodule

// File: tb/tb_dw_mac_array.sv
// Randomized scoreboard bench for dw_mac_array with a per-window dot-product reference model.
module tb_dw_mac_array;
  import dw_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 w_valid = 1'b0;
  logic [TAP_IDX_W-1:0] w_idx = '0;
  logic [VEC_W-1:0]     w_data = '0;
  logic                 weights_ready;
  logic                 act_valid = 1'b0;
  logic                 act_ready;
  logic [VEC_W-1:0]     act_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [OUT_W-1:0]     out_data;
  logic                 window_abort;

  always #5 clk = ~clk;

  dw_mac_array dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .w_valid       (w_valid),
    .w_idx         (w_idx),
    .w_data        (w_data),
    .weights_ready (weights_ready),
    .act_valid     (act_valid),
    .act_ready     (act_ready),
    .act_data      (act_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .window_abort  (window_abort)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: weight table, tap mask, running per-lane dot products.
  logic [VEC_W-1:0] m_wt [KK];
  logic [KK-1:0]    m_mask = '0;
  int               m_tap = 0;
  int               m_acc [UNIT_NUM];
  logic             exp_wr = 1'b0;
  logic             exp_abort = 1'b0;
  logic             m_hs, m_new;
  logic [OUT_W-1:0] m_vec;
  logic [OUT_W-1:0] exp_q [$];
  logic             held = 1'b0;
  logic [OUT_W-1:0] held_data = '0;

  logic [VEC_W-1:0] wset [KK];
  logic [VEC_W-1:0] aset [KK];
  bit               rand_rdy = 1'b0;
  bit               junk = 1'b0;

  task automatic check_bit(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", nm, got, exp);
    end
  endtask

  task automatic check_vec(input string nm, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic model_clear_window();
    m_tap = 0;
    for (int l = 0; l < UNIT_NUM; l++) m_acc[l] = 0;
  endtask

  // Monitor + model: compare registered outputs, then fold in this cycle's handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_mask = '0;
      exp_wr = 1'b0;
      exp_abort = 1'b0;
      model_clear_window();
      exp_q.delete();
      held = 1'b0;
    end else begin
      check_bit("weights_ready", weights_ready, exp_wr);
      check_bit("window_abort", window_abort, exp_abort);
      if (!exp_wr) check_bit("act_ready_off", act_ready, 1'b0);
      else if (m_tap != KK - 1) check_bit("act_ready_on", act_ready, 1'b1);
      if (held) begin
        check_bit("stall_valid", out_valid, 1'b1);
        check_vec("stall_data", out_data, held_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got=%h exp=none", out_data);
        end else begin
          check_vec("out_data", out_data, exp_q.pop_front());
        end
      end
      held = out_valid && !out_ready;
      held_data = out_data;

      m_hs  = act_valid && act_ready;
      m_new = w_valid && (w_idx == '0);
      exp_abort = 1'b0;
      if (m_new) begin
        exp_abort = (m_tap != 0) || m_hs;
        model_clear_window();
      end else if (m_hs) begin
        for (int l = 0; l < UNIT_NUM; l++)
          m_acc[l] += int'($signed(m_wt[m_tap][l*LANE_W +: LANE_W])) *
                      int'($signed(act_data[l*LANE_W +: LANE_W]));
        m_tap++;
        if (m_tap == KK) begin
          for (int l = 0; l < UNIT_NUM; l++) m_vec[l*ACC_W +: ACC_W] = ACC_W'(m_acc[l]);
          exp_q.push_back(m_vec);
          model_clear_window();
        end
      end
      if (w_valid && (w_idx < TAP_IDX_W'(KK))) begin
        m_wt[w_idx] = w_data;
        m_mask = m_new ? KK'(1) : (m_mask | (KK'(1) << w_idx));
      end
      exp_wr = (m_mask == {KK{1'b1}});
    end
  end

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [VEC_W-1:0] v;
    for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VEC_W-1:0] splat(input int v);
    logic [VEC_W-1:0] r;
    for (int l = 0; l < UNIT_NUM; l++) r[l*LANE_W +: LANE_W] = LANE_W'(v);
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] splat_acc(input int v);
    logic [OUT_W-1:0] r;
    for (int l = 0; l < UNIT_NUM; l++) r[l*ACC_W +: ACC_W] = ACC_W'(v);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_set();
    idle(2);
    for (int t = 0; t < KK; t++) begin
      if (junk) begin
        w_valid = 1'b1;
        w_idx   = TAP_IDX_W'($urandom_range(9, 15));
        w_data  = rand_vec();
        tick();
      end
      w_valid = 1'b1;
      w_idx   = TAP_IDX_W'(t);
      w_data  = wset[t];
      tick();
    end
    w_valid = 1'b0;
    w_idx   = '0;
  endtask

  task automatic drive_act(input logic [VEC_W-1:0] d);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    act_valid = 1'b1;
    act_data  = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = act_ready;
      tick();
      n++;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL act_timeout got=no_accept exp=accept");
    end
    act_valid = 1'b0;
  endtask

  task automatic stream_window();
    for (int t = 0; t < KK; t++) drive_act(aset[t]);
  endtask

  // Full window with out_ready high: result must appear exactly two cycles after the last tap.
  task automatic window_direct(input string nm, input logic [OUT_W-1:0] expv);
    stream_window();
    check_bit({nm, "_lat1"}, out_valid, 1'b0);
    tick();
    check_bit({nm, "_lat2"}, out_valid, 1'b1);
    check_vec({nm, "_data"}, out_data, expv);
    idle(2);
  endtask

  initial begin
    logic [OUT_W-1:0] ev;
    int n;

    #12;
    check_bit("rst_weights_ready", weights_ready, 1'b0);
    check_bit("rst_act_ready", act_ready, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_data", out_data, '0);
    check_bit("rst_window_abort", window_abort, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Unit weights, activations of 2.
    for (int t = 0; t < KK; t++) wset[t] = splat(1);
    load_set();
    check_bit("wr_after_tap8", weights_ready, 1'b1);
    for (int t = 0; t < KK; t++) aset[t] = splat(2);
    window_direct("ones", splat_acc(18));

    // Most-negative corner.
    for (int t = 0; t < KK; t++) wset[t] = splat(-128);
    load_set();
    for (int t = 0; t < KK; t++) aset[t] = splat(-128);
    window_direct("neg_corner", splat_acc(147456));

    // Lane-dependent signed weights.
    for (int t = 0; t < KK; t++)
      for (int l = 0; l < UNIT_NUM; l++) wset[t][l*LANE_W +: LANE_W] = LANE_W'(l - 8);
    load_set();
    for (int t = 0; t < KK; t++) aset[t] = splat(3);
    for (int l = 0; l < UNIT_NUM; l++) ev[l*ACC_W +: ACC_W] = ACC_W'(27 * (l - 8));
    window_direct("signed_ramp", ev);

    // Back-pressure: tap 8 of the next window waits for the stalled result.
    for (int t = 0; t < KK; t++) wset[t] = rand_vec();
    load_set();
    out_ready = 1'b0;
    for (int t = 0; t < KK; t++) aset[t] = rand_vec();
    stream_window();
    idle(3);
    check_bit("stall_a_valid", out_valid, 1'b1);
    for (int t = 0; t < KK; t++) aset[t] = rand_vec();
    for (int t = 0; t < KK - 1; t++) drive_act(aset[t]);
    act_valid = 1'b1;
    act_data  = aset[KK-1];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("tap8_blocked", act_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_bit("tap8_release", act_ready, 1'b1);
    tick();
    act_valid = 1'b0;
    check_bit("stall_b_lat1", out_valid, 1'b0);
    tick();
    check_bit("stall_b_lat2", out_valid, 1'b1);
    idle(3);

    // New weight set after four beats aborts the partial window.
    for (int t = 0; t < KK; t++) wset[t] = splat(5);
    load_set();
    for (int t = 0; t < KK; t++) aset[t] = splat(7);
    for (int t = 0; t < 4; t++) drive_act(aset[t]);
    tick();
    w_valid = 1'b1;
    w_idx   = '0;
    w_data  = splat(-3);
    tick();
    check_bit("abort_pulse", window_abort, 1'b1);
    check_bit("abort_wr_low", weights_ready, 1'b0);
    check_bit("abort_act_low", act_ready, 1'b0);
    for (int t = 1; t < KK; t++) begin
      w_idx  = TAP_IDX_W'(t);
      w_data = splat(-3);
      tick();
    end
    w_valid = 1'b0;
    w_idx   = '0;
    check_bit("abort_reload_wr", weights_ready, 1'b1);
    window_direct("after_abort", splat_acc(-189));

    // Out-of-range tap indices interleaved with a real load.
    junk = 1'b1;
    for (int t = 0; t < KK; t++) wset[t] = rand_vec();
    load_set();
    junk = 1'b0;
    for (int t = 0; t < KK; t++) aset[t] = rand_vec();
    stream_window();
    idle(3);

    // Random sets, windows and back-pressure.
    rand_rdy = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int t = 0; t < KK; t++) wset[t] = rand_vec();
      load_set();
      for (int w = 0; w < 3; w++) begin
        for (int t = 0; t < KK; t++) aset[t] = rand_vec();
        stream_window();
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    idle(4);

    // Asynchronous reset with a stalled result and a partial window.
    out_ready = 1'b0;
    for (int t = 0; t < KK; t++) aset[t] = rand_vec();
    stream_window();
    for (int t = 0; t < 3; t++) drive_act(rand_vec());
    check_bit("pre_rst_valid", out_valid, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_bit("arst_weights_ready", weights_ready, 1'b0);
    check_bit("arst_act_ready", act_ready, 1'b0);
    check_bit("arst_out_valid", out_valid, 1'b0);
    check_vec("arst_out_data", out_data, '0);
    check_bit("arst_window_abort", window_abort, 1'b0);
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    act_valid = 1'b1;
    act_data  = rand_vec();
    idle(4);
    check_bit("post_rst_act_low", act_ready, 1'b0);
    for (int t = 0; t < KK; t++) wset[t] = rand_vec();
    load_set();
    act_valid = 1'b0;
    for (int t = 0; t < KK; t++) aset[t] = rand_vec();
    stream_window();

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL results_drained got=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
